// File: rtl/div_pkg.sv
// Shared types and constants for the handshaked restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Quotient reported on divide-by-zero; sliced to the operand width by users.
  localparam logic [63:0] DBZ_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: trial subtract, keep or restore.
module div_restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial_s;

  // A set MSB on the WIDTH+1-bit difference means the trial went negative.
  always_comb begin
    trial_s = partial - {1'b0, divisor};
    if (trial_s[WIDTH] == 1'b0) begin
      rem_next = trial_s[WIDTH-1:0];
      q_bit    = 1'b1;
    end else begin
      rem_next = partial[WIDTH-1:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/divider_hs.sv
// Sequential restoring divider with valid/ready handshakes, one quotient bit per cycle.
// Signed operation is compiled in only when DIVIDER_HS_SIGNED_EN is defined.
module divider_hs
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1'b1);
  endfunction

  div_state_t       state_r, state_next_s;
  logic [CNTW-1:0]  cnt_r;
  logic [WIDTH-1:0] dvd_r, dvs_r, part_r;
  logic             neg_q_r, neg_r_r, dbz_r, ovf_r;
  logic             a_neg_s, b_neg_s, ovf_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s, q_fix_s, r_fix_s, step_rem_s;
  logic             step_q_s;

`ifdef DIVIDER_HS_SIGNED_EN
  // Operand signs and the MIN / -1 case, only meaningful in signed mode.
  always_comb begin
    a_neg_s = signed_mode & dividend[WIDTH-1];
    b_neg_s = signed_mode & divisor[WIDTH-1];
    ovf_s   = signed_mode && (dividend == MIN_W) && (divisor == ONES_W);
  end
`else
  logic unused_signed_s;
  assign unused_signed_s = signed_mode ^ MIN_W[WIDTH-1];
  assign a_neg_s = 1'b0;
  assign b_neg_s = 1'b0;
  assign ovf_s   = 1'b0;
`endif

  // Magnitudes going in and sign correction coming out; |MIN| is exact as unsigned.
  always_comb begin
    abs_a_s = a_neg_s ? neg2c(dividend) : dividend;
    abs_b_s = b_neg_s ? neg2c(divisor) : divisor;
    q_fix_s = neg_q_r ? neg2c(dvd_r) : dvd_r;
    r_fix_s = neg_r_r ? neg2c(part_r) : part_r;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .partial  ({part_r, dvd_r[WIDTH-1]}),
    .divisor  (dvs_r),
    .rem_next (step_rem_s),
    .q_bit    (step_q_s)
  );

  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = (divisor == ZERO_W) ? POST : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {CNTW{1'b0}}) begin
          state_next_s = POST;
        end else begin
          state_next_s = CALC;
        end
      end
      POST: state_next_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CNTW{1'b0}};
      dvd_r       <= ZERO_W;
      dvs_r       <= ZERO_W;
      part_r      <= ZERO_W;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= ZERO_W;
      remainder   <= ZERO_W;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            cnt_r       <= CNTW'(WIDTH - 1);
            dvs_r       <= abs_b_s;
            part_r      <= ZERO_W;
            neg_q_r     <= a_neg_s ^ b_neg_s;
            neg_r_r     <= a_neg_s;
            dbz_r       <= (divisor == ZERO_W);
            ovf_r       <= ovf_s;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            // Divide-by-zero returns the raw dividend as remainder.
            dvd_r       <= (divisor == ZERO_W) ? dividend : abs_a_s;
          end
        end
        CALC: begin
          part_r <= step_rem_s;
          dvd_r  <= {dvd_r[WIDTH-2:0], step_q_s};
          cnt_r  <= cnt_r - CNTW'(1'b1);
        end
        POST: begin
          out_valid <= 1'b1;
          if (dbz_r) begin
            quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= q_fix_s;
            remainder   <= r_fix_s;
            div_by_zero <= 1'b0;
            overflow    <= ovf_r;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_hs.sv
// Directed self-checking bench for divider_hs at WIDTH=8.
module tb_divider_hs;

`ifdef DIVIDER_HS_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, signed_mode, out_ready;
  logic [7:0] dividend, divisor;
  logic       in_ready, out_valid, div_by_zero, overflow, busy;
  logic [7:0] quotient, remainder;

  int n_checks = 0;
  int n_pass   = 0;

  divider_hs #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Run one operation, optionally stall the consumer, then consume while offering new operands.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                       input logic eovf, input int elat, input int stall);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b; signed_mode = sm;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = 8'h5A; divisor = 8'h00; signed_mode = ~sm;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, " latency"}, cyc, elat);
    check({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
    check({tag, " remainder"}, {24'd0, remainder}, {24'd0, er});
    check({tag, " flags"}, {30'd0, div_by_zero, overflow}, {30'd0, edbz, eovf});
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; dividend = 8'd77; divisor = 8'd5;
      @(posedge clk); #1;
      check({tag, " stall hold"}, {14'd0, out_valid, in_ready, quotient, remainder},
            {14'd0, 1'b1, 1'b0, eq, er});
    end
    out_ready = 1'b1; in_valid = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check({tag, " consume"}, {29'd0, out_valid, busy, in_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b0;
    dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset outputs", {12'd0, out_valid, div_by_zero, overflow, busy, in_ready, quotient, remainder},
          {12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0});

    do_op("u100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0, 9, 0);
    do_op("u5_0", 8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1, 1'b0, 1, 0);
    do_op("s-7_2", 8'hF9, 8'h02, 1'b1, SIGNED_EN ? 8'hFD : 8'd124,
          SIGNED_EN ? 8'hFF : 8'd1, 1'b0, 1'b0, 9, 0);
    do_op("s-128_-1", 8'h80, 8'hFF, 1'b1, SIGNED_EN ? 8'h80 : 8'h00,
          SIGNED_EN ? 8'h00 : 8'h80, 1'b0, SIGNED_EN, 9, 0);
    do_op("s7_-2", 8'h07, 8'hFE, 1'b1, SIGNED_EN ? 8'hFD : 8'h00,
          SIGNED_EN ? 8'h01 : 8'h07, 1'b0, 1'b0, 9, 0);
    do_op("u200_13", 8'd200, 8'd13, 1'b0, 8'd15, 8'd5, 1'b0, 1'b0, 9, 0);
    do_op("u255_1 stall", 8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, 1'b0, 9, 5);

    // Abort during the third iteration.
    in_valid = 1'b1; dividend = 8'd200; divisor = 8'd3; signed_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort state", {29'd0, busy, out_valid, in_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
    repeat (12) @(posedge clk);
    #1;
    check("abort no result", {31'd0, out_valid}, 32'd0);
    do_op("u9_3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 9, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
